out_mem_dump: RTL and testbench

- Parametrised output buffer memory for an accelerator channel.
- Captures LANES-byte result words on a byte-addressed write port, with per-lane byte enables.
- On a rising edge of done, streams the first DUMP_WORDS words out over a valid/ready interface to the testbench writer or a downstream DMA.
- Replaces file-dumping output memories with a synthesizable, handshaked drain path.

---
 rtl/out_mem_pkg.sv | 11 +
 rtl/out_mem_ram.sv | 36 +++
 rtl/out_mem_dump.sv | 133 +++++++++++++
 tb/tb_out_mem_dump.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_mem_pkg.sv
// Shared types and helpers for the output dump memory.
package out_mem_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, SEND, FIN} dump_state_t;

    // Index width that stays at least one bit wide for single-entry arrays.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/out_mem_ram.sv
// Single-port byte-enable RAM with a registered read port.
module out_mem_ram
    import out_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned LANES  = 4,
    parameter int unsigned LANE_W = 8,
    localparam int unsigned IW    = clog2_min1(DEPTH)
) (
    input  logic                      i_clk,
    input  logic                      i_we,
    input  logic [LANES-1:0]          i_be,
    input  logic [IW-1:0]             i_waddr,
    input  logic [LANES*LANE_W-1:0]   i_wdata,
    input  logic [IW-1:0]             i_raddr,
    output logic [LANES*LANE_W-1:0]   o_rdata
);

    logic [LANES*LANE_W-1:0] r_mem [DEPTH];
    logic [LANES*LANE_W-1:0] r_rdata;

    // Byte-gated write; read data registered one cycle after the address.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int unsigned j = 0; j < LANES; j++) begin
                if (i_be[j]) begin
                    r_mem[i_waddr][j*LANE_W +: LANE_W] <= i_wdata[j*LANE_W +: LANE_W];
                end
            end
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/out_mem_dump.sv
// Output buffer memory: byte-enabled capture, then a valid/ready drain of the first
// DUMP_WORDS words on each rising edge of done.
module out_mem_dump
    import out_mem_pkg::*;
#(
    parameter int unsigned CAPACITY   = 256,
    parameter int unsigned LANES      = 4,
    parameter int unsigned LANE_W     = 8,
    parameter int unsigned DUMP_WORDS = 43,
    parameter int unsigned CH_ID      = 0,
    localparam int unsigned DEPTH     = CAPACITY / LANES,
    localparam int unsigned AW        = clog2_min1(CAPACITY),
    localparam int unsigned IW        = clog2_min1(DEPTH),
    localparam int unsigned LW        = $clog2(LANES)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_write_en,
    input  logic [AW-1:0]             i_addr,
    input  logic [LANE_W-1:0]         i_inp [0:LANES-1],
    input  logic [LANES-1:0]          i_byte_en,
    input  logic                      i_done,
    output logic                      o_dump_valid,
    input  logic                      i_dump_ready,
    output logic [LANES*LANE_W-1:0]   o_dump_data,
    output logic [IW-1:0]             o_dump_idx,
    output logic                      o_dump_last,
    output logic [7:0]                o_dump_ch,
    output logic                      o_busy,
    output logic                      o_dump_done,
    output logic                      o_wr_err
);

    if (DUMP_WORDS < 1 || DUMP_WORDS > DEPTH) begin : g_bad_cfg
        $error("out_mem_dump: DUMP_WORDS must be in 1..DEPTH");
    end

    localparam logic [IW-1:0] LAST_IDX = IW'(DUMP_WORDS - 1);

    dump_state_t             r_state, w_state_d;
    logic [IW-1:0]           r_cnt, w_cnt_d;
    logic                    r_done_q;
    logic                    r_wr_err;
    logic                    w_start;
    logic                    w_in_range;
    logic                    w_we;
    logic                    w_wr_rej;
    logic [AW-1:0]           w_word;
    logic [LANES*LANE_W-1:0] w_wdata;
    logic [LANES*LANE_W-1:0] w_rdata;

    assign w_word     = i_addr >> LW;
    assign w_in_range = (32'(w_word) < DEPTH);
    assign w_we       = i_write_en && (r_state == IDLE) && w_in_range;
    assign w_wr_rej   = i_write_en && !((r_state == IDLE) && w_in_range);
    assign w_start    = i_done & ~r_done_q;

    // Pack lanes MSB-first so inp[0] lands in the top byte; byte_en bits follow the
    // same byte positions as the stored word.
    always_comb begin
        w_wdata = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_wdata[(LANES-1-i)*LANE_W +: LANE_W] = i_inp[i];
        end
    end

    out_mem_ram #(
        .DEPTH  (DEPTH),
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_be    (i_byte_en),
        .i_waddr (w_word[IW-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (r_cnt),
        .o_rdata (w_rdata)
    );

    // State, word counter, done-edge history and write-reject pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_done_q <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_done_q <= i_done;
            r_wr_err <= w_wr_rej;
        end
    end

    // Next-state: fetch one word, hold it until accepted, repeat up to the last index.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_d = FETCH;
                    w_cnt_d   = '0;
                end
            end
            FETCH: w_state_d = SEND;
            SEND: begin
                if (i_dump_ready) begin
                    if (r_cnt == LAST_IDX) begin
                        w_state_d = FIN;
                    end else begin
                        w_cnt_d   = r_cnt + 1'b1;
                        w_state_d = FETCH;
                    end
                end
            end
            FIN:     w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // Read data is only exposed while offered, so it reads as zero out of reset.
    assign o_dump_valid = (r_state == SEND);
    assign o_dump_data  = o_dump_valid ? w_rdata : '0;
    assign o_dump_idx   = r_cnt;
    assign o_dump_last  = o_dump_valid && (r_cnt == LAST_IDX);
    assign o_dump_ch    = 8'(CH_ID);
    assign o_busy       = (r_state == FETCH) || (r_state == SEND);
    assign o_dump_done  = (r_state == FIN);
    assign o_wr_err     = r_wr_err;

endmodule

// File: tb/tb_out_mem_dump.sv
// Directed bench for out_mem_dump: vector tables plus hand sequences for the dump corners.
module tb_out_mem_dump;

    // 252 bytes -> 63 words, so byte addresses 252..255 fall beyond the last word.
    localparam int unsigned CAPACITY = 252;
    localparam int unsigned NW       = 43;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        write_en;
    logic [7:0]  addr;
    logic [7:0]  inp [0:3];
    logic [3:0]  byte_en;
    logic        done;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic [5:0]  dump_idx;
    logic        dump_last;
    logic [7:0]  dump_ch;
    logic        busy;
    logic        dump_done;
    logic        wr_err;

    int n_vec = 0;
    int n_err = 0;
    int beats;
    int done_cyc;
    logic [31:0] model [63];
    logic [31:0] cap   [63];

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
        logic        exp_err;
    } wvec_t;

    typedef struct {
        int          idx;
        logic [31:0] exp;
    } rvec_t;

    wvec_t wv [7];
    rvec_t rv1 [3];
    rvec_t rv2 [6];

    always #5 clk = ~clk;

    out_mem_dump #(
        .CAPACITY   (CAPACITY),
        .LANES      (4),
        .LANE_W     (8),
        .DUMP_WORDS (NW),
        .CH_ID      (3)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_write_en   (write_en),
        .i_addr       (addr),
        .i_inp        (inp),
        .i_byte_en    (byte_en),
        .i_done       (done),
        .o_dump_valid (dump_valid),
        .i_dump_ready (dump_ready),
        .o_dump_data  (dump_data),
        .o_dump_idx   (dump_idx),
        .o_dump_last  (dump_last),
        .o_dump_ch    (dump_ch),
        .o_busy       (busy),
        .o_dump_done  (dump_done),
        .o_wr_err     (wr_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_inp(input logic [31:0] d);
        for (int i = 0; i < 4; i++) inp[i] = d[(3-i)*8 +: 8];
    endtask

    // Expected memory update: byte_en bit j covers word byte j.
    task automatic model_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        int w;
        w = int'(a) / 4;
        for (int j = 0; j < 4; j++) if (be[j]) model[w][j*8 +: 8] = d[j*8 +: 8];
    endtask

    // Called at a negedge; returns at the next negedge with the reject flag sampled.
    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                      output logic err);
        write_en = 1'b1;
        addr     = a;
        set_inp(d);
        byte_en  = be;
        @(negedge clk);
        err      = wr_err;
        write_en = 1'b0;
        byte_en  = 4'h0;
    endtask

    // Raises done and follows the stream. mode 0: ready held high; mode 1: ready 0,0,1 per beat.
    // abort >= 0 asserts reset when beat 'abort' is first offered. glitch/wr_at are cycle
    // numbers for a second done edge and a write during the dump (0 = off).
    task automatic do_dump(input int mode, input int abort, input int glitch, input int wr_at,
                           input bit coincide, input logic [31:0] cdata);
        bit          holding;
        bit          fin;
        int          stall;
        logic [31:0] hd;
        logic [5:0]  hi;
        holding    = 1'b0;
        fin        = 1'b0;
        stall      = 0;
        hd         = '0;
        hi         = '0;
        beats      = 0;
        done_cyc   = -1;
        dump_ready = (mode == 0);
        done       = 1'b1;
        if (coincide) begin
            write_en = 1'b1;
            addr     = 8'd0;
            set_inp(cdata);
            byte_en  = 4'hF;
            model[0] = cdata;
        end
        for (int cyc = 1; cyc <= 1000 && !fin; cyc++) begin
            @(negedge clk);
            if (coincide && cyc == 1) begin
                chk("coincide_wr_err", 32'(wr_err), 32'd0);
                write_en = 1'b0;
                byte_en  = 4'h0;
            end
            if (cyc == 1) begin
                chk("start_busy", 32'(busy), 32'd1);
                chk("start_no_valid", 32'(dump_valid), 32'd0);
            end
            if (cyc == 2) chk("first_valid_lat", 32'(dump_valid), 32'd1);
            if (glitch > 0 && cyc == glitch) done = 1'b0;
            if (glitch > 0 && cyc == glitch + 2) done = 1'b1;
            if (wr_at > 0 && cyc == wr_at) begin
                write_en = 1'b1;
                addr     = 8'd0;
                set_inp(32'hDEADBEEF);
                byte_en  = 4'hF;
            end
            if (wr_at > 0 && cyc == wr_at + 1) begin
                chk("busy_wr_err", 32'(wr_err), 32'd1);
                write_en = 1'b0;
                byte_en  = 4'h0;
            end
            if (wr_at > 0 && cyc == wr_at + 2) chk("busy_wr_err_pulse", 32'(wr_err), 32'd0);
            if (dump_done) begin
                done_cyc = cyc;
                fin      = 1'b1;
            end else if (dump_valid) begin
                if (abort >= 0 && beats == abort) begin
                    rst_n = 1'b0;
                    done  = 1'b0;
                    fin   = 1'b1;
                end else begin
                    if (holding) begin
                        chk("hold_data", dump_data, hd);
                        chk("hold_idx", 32'(dump_idx), 32'(hi));
                    end
                    if (mode == 1 && stall < 2) begin
                        dump_ready = 1'b0;
                        stall++;
                        holding = 1'b1;
                        hd      = dump_data;
                        hi      = dump_idx;
                    end else begin
                        dump_ready = 1'b1;
                        stall      = 0;
                        holding    = 1'b0;
                        chk("beat_idx", 32'(dump_idx), 32'(beats));
                        if (beats < 63) begin
                            chk("beat_data", dump_data, model[beats]);
                            cap[beats] = dump_data;
                        end
                        chk("beat_last", 32'(dump_last), (beats == NW - 1) ? 32'd1 : 32'd0);
                        beats++;
                    end
                end
            end else if (holding) begin
                chk("hold_valid", 32'(dump_valid), 32'd1);
                holding = 1'b0;
            end
        end
        if (!fin) chk("dump_timeout", 32'd0, 32'd1);
    endtask

    // Counts cycles with dump_valid or dump_done over a window.
    task automatic quiet(input int n, output int hits);
        hits = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (dump_valid || dump_done) hits++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic err;
        int   hits;

        wv[0] = '{8'd20,  32'hAABBCCDD, 4'hF,    1'b0};
        wv[1] = '{8'd22,  32'h11223344, 4'b0101, 1'b0};
        wv[2] = '{8'd252, 32'hFFFFFFFF, 4'hF,    1'b1};
        wv[3] = '{8'd255, 32'hFFFFFFFF, 4'hF,    1'b1};
        wv[4] = '{8'd7,   32'h0000EE00, 4'b0010, 1'b0};
        wv[5] = '{8'd168, 32'h12345678, 4'b1000, 1'b0};
        wv[6] = '{8'd100, 32'hCAFEF00D, 4'b0000, 1'b0};
        rv1[0] = '{0,  32'h00010203};
        rv1[1] = '{17, 32'h11121314};
        rv1[2] = '{42, 32'h2A2B2C2D};
        rv2[0] = '{5,  32'hAA22CC44};
        rv2[1] = '{1,  32'h0102EE04};
        rv2[2] = '{42, 32'h122B2C2D};
        rv2[3] = '{25, 32'h191A1B1C};
        rv2[4] = '{0,  32'h00010203};
        rv2[5] = '{6,  32'h06070809};

        rst_n      = 1'b0;
        write_en   = 1'b0;
        addr       = 8'd0;
        byte_en    = 4'h0;
        done       = 1'b0;
        dump_ready = 1'b0;
        set_inp(32'h0);
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(dump_valid), 32'd0);
        chk("rst_last", 32'(dump_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dump_done", 32'(dump_done), 32'd0);
        chk("rst_wr_err", 32'(wr_err), 32'd0);
        chk("rst_idx", 32'(dump_idx), 32'd0);
        chk("rst_data", dump_data, 32'd0);
        chk("dump_ch", 32'(dump_ch), 32'd3);
        rst_n = 1'b1;
        @(negedge clk);

        // Full-word fill with {k,k+1,k+2,k+3}, then an unthrottled dump.
        for (int k = 0; k < int'(NW); k++) begin
            logic [31:0] d;
            d = {8'(k), 8'(k + 1), 8'(k + 2), 8'(k + 3)};
            wr(8'(4 * k), d, 4'hF, err);
            chk("fill_wr_err", 32'(err), 32'd0);
            model[k] = d;
        end
        @(negedge clk);
        do_dump(0, -1, 0, 0, 1'b0, 32'h0);
        chk("beat_count", 32'(beats), 32'(NW));
        chk("done_cycle", 32'(done_cyc), 32'd87);
        done = 1'b0;
        @(negedge clk);
        chk("done_pulse_1cyc", 32'(dump_done), 32'd0);
        for (int i = 0; i < 3; i++) chk("readback1", cap[rv1[i].idx], rv1[i].exp);

        // Byte-enable and range vectors.
        for (int i = 0; i < 7; i++) begin
            wr(wv[i].a, wv[i].d, wv[i].be, err);
            chk("wvec_wr_err", 32'(err), 32'(wv[i].exp_err));
            if (!wv[i].exp_err) model_wr(wv[i].a, wv[i].d, wv[i].be);
        end
        @(negedge clk);

        // Backpressured dump with a second done edge at cycle 20 and a write at cycle 30.
        do_dump(1, -1, 20, 30, 1'b0, 32'h0);
        chk("beat_count_bp", 32'(beats), 32'(NW));
        chk("done_cycle_bp", 32'(done_cyc), 32'd173);
        done = 1'b0;
        quiet(20, hits);
        chk("no_queued_dump", 32'(hits), 32'd0);
        for (int i = 0; i < 6; i++) chk("readback2", cap[rv2[i].idx], rv2[i].exp);

        // Dump again with done then held high: word 0 must still be the old value.
        do_dump(0, -1, 0, 0, 1'b0, 32'h0);
        chk("old_word0", cap[0], 32'h00010203);
        quiet(100, hits);
        chk("held_done_once", 32'(hits), 32'd0);
        done = 1'b0;
        @(negedge clk);

        // Done edge in the same cycle as a write to word 0.
        do_dump(0, -1, 0, 0, 1'b1, 32'h55667788);
        chk("coincide_word0", cap[0], 32'h55667788);
        chk("done_cycle_coinc", 32'(done_cyc), 32'd87);
        done = 1'b0;
        @(negedge clk);

        // Reset while beat 10 is offered.
        do_dump(0, 10, 0, 0, 1'b0, 32'h0);
        chk("abort_beats", 32'(beats), 32'd10);
        @(negedge clk);
        chk("abort_valid", 32'(dump_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_dump_done", 32'(dump_done), 32'd0);
        rst_n = 1'b1;
        quiet(10, hits);
        chk("abort_quiet", 32'(hits), 32'd0);

        // Fresh dump after reset starts at index 0 with memory intact.
        do_dump(0, -1, 0, 0, 1'b0, 32'h0);
        chk("beat_count_post", 32'(beats), 32'(NW));
        chk("done_cycle_post", 32'(done_cyc), 32'd87);
        chk("post_word0", cap[0], 32'h55667788);
        chk("post_word5", cap[5], 32'hAA22CC44);
        done = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
